// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between an instruction-fetch
// port and a load/store port. At most one access is in flight, and the two
// requesters alternate on contention. The RAM has a fixed read latency of
// RAM_LAT cycles; the legal range is 1..7, which fits the 3-bit wait counter.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  // RAM side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  // identity and direction of the access in flight
  typedef struct packed {
    owner_e owner;
    logic   we;
  } txn_t;

  state_e            state_q, state_d;
  txn_t              txn_q, txn_d;
  owner_e            last_owner_q, last_owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic if_win, d_win, idle;

  // grant is combinational from req in IDLE; on contention the port that
  // did not win last time takes it
  always_comb begin
    idle   = (state_q == IDLE) && !reset;
    if_win = if_req && (!d_req || (last_owner_q == OWN_D));
    d_win  = d_req && !if_win;
    if_gnt = idle && if_win;
    d_gnt  = idle && d_win;
  end

  // next-state and registered-output logic for the access sequencer
  always_comb begin
    state_d      = state_q;
    txn_d        = txn_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    busy_d       = busy_q;
    unique case (state_q)
      IDLE: begin
        if (if_gnt || d_gnt) begin
          txn_d.owner  = d_gnt ? OWN_D : OWN_IF;
          txn_d.we     = d_gnt && d_we;
          last_owner_d = d_gnt ? OWN_D : OWN_IF;
          // strobe and operands are registered here so they are
          // presented to the RAM for exactly the ISSUE cycle
          mem_en_d     = 1'b1;
          mem_we_d     = d_gnt && d_we;
          mem_addr_d   = d_gnt ? d_addr : if_addr;
          mem_wdata_d  = d_gnt ? d_wdata : mem_wdata_q;
          busy_d       = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 3'(RAM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // WAIT lasts RAM_LAT cycles, so the edge leaving it is the one
        // RAM_LAT edges after ISSUE, where mem_rdata is valid; done then
        // lands at grant + RAM_LAT + 2
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          if (txn_q.owner == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            if (!txn_q.we) d_rdata_d = mem_rdata;
            d_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register; reset abandons any in-flight access without a done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      txn_q        <= '{owner: OWN_IF, we: 1'b0};
      last_owner_q <= OWN_D;
      cnt_q        <= 3'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      txn_q        <= txn_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: three arbiters (RAM_LAT 2, 1, 7) driven in lockstep,
// each with its own RAM model. Grants push expected accesses to a
// scoreboard; RAM strobes and done pulses pop and compare.
module tb_mem_port_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] if_req, if_gnt, if_done, d_req, d_gnt, d_done, mem_en, mem_we, busy;
  logic         d_we;
  logic [31:0]  if_addr, d_addr, d_wdata;
  logic [31:0]  if_rdata [N];
  logic [31:0]  d_rdata [N];
  logic [31:0]  mem_addr [N];
  logic [31:0]  mem_wdata [N];
  logic [31:0]  mem_rdata [N];

  typedef struct {
    int          k;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    int          gcyc;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] last_d [N];
  int          n_dgnt [N];
  int          n_done [N];
  int          n_men [N];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 7;
  endfunction

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] exp_word(logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  function automatic int find(int k);
    foreach (sbq[i]) if (sbq[i].k == k) return i;
    return -1;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 2 : (k == 1) ? 1 : 7;
    logic [31:0]  ram [256];
    logic [255:0] wr = '0;
    logic [31:0]  pipe [7];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[k]), .if_addr(if_addr), .if_gnt(if_gnt[k]),
      .if_done(if_done[k]), .if_rdata(if_rdata[k]),
      .d_req(d_req[k]), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt[k]), .d_done(d_done[k]), .d_rdata(d_rdata[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]), .busy(busy[k])
    );

    // RAM model: data for a strobe appears LAT edges later, junk otherwise
    always @(posedge clk) begin
      if (mem_en[k] && mem_we[k]) begin
        ram[mem_addr[k][7:0]] <= mem_wdata[k];
        wr[mem_addr[k][7:0]]  <= 1'b1;
      end
      pipe[0] <= !mem_en[k] ? 32'hBAD0BAD0 :
                 wr[mem_addr[k][7:0]] ? ram[mem_addr[k][7:0]] : init_word(mem_addr[k]);
      for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[k] = pipe[LAT-1];
  end

  // monitor: push on grant, pop on RAM strobe / done
  always @(negedge clk) begin
    sb_t t;
    int  idx;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        if (if_gnt[k] || d_gnt[k]) begin
          chk($sformatf("gnt_onehot[%0d]", k), 64'(if_gnt[k] & d_gnt[k]), 64'd0);
          chk($sformatf("gnt_idle[%0d]", k), 64'(busy[k]), 64'd0);
          if (d_gnt[k]) n_dgnt[k]++;
          t.k     = k;
          t.is_d  = d_gnt[k];
          t.we    = d_gnt[k] && d_we;
          t.addr  = d_gnt[k] ? d_addr : if_addr;
          t.wdata = d_wdata;
          t.data  = exp_word(t.addr);
          t.gcyc  = cyc;
          sbq.push_back(t);
        end
        if (mem_en[k]) begin
          n_men[k]++;
          idx = find(k);
          chk($sformatf("men_owner[%0d]", k), 64'(idx >= 0), 64'd1);
          if (idx >= 0) begin
            t = sbq[idx];
            chk($sformatf("men_cyc[%0d]", k), 64'(cyc - t.gcyc), 64'd1);
            chk($sformatf("men_addr[%0d]", k), 64'(mem_addr[k]), 64'(t.addr));
            chk($sformatf("men_we[%0d]", k), 64'(mem_we[k]), 64'(t.we));
            if (t.we) chk($sformatf("men_wdata[%0d]", k), 64'(mem_wdata[k]), 64'(t.wdata));
          end
        end
        if (if_done[k] || d_done[k]) begin
          n_done[k]++;
          idx = find(k);
          chk($sformatf("done_owner[%0d]", k), 64'(idx >= 0), 64'd1);
          if (idx >= 0) begin
            t = sbq[idx];
            chk($sformatf("done_cyc[%0d]", k), 64'(cyc - t.gcyc), 64'(lat_of(k) + 2));
            chk($sformatf("done_port[%0d]", k), 64'({if_done[k], d_done[k]}),
                t.is_d ? 64'd1 : 64'd2);
            if (!t.is_d)
              chk($sformatf("if_rdata[%0d]", k), 64'(if_rdata[k]), 64'(t.data));
            else if (!t.we) begin
              chk($sformatf("d_rdata[%0d]", k), 64'(d_rdata[k]), 64'(t.data));
              last_d[k] = t.data;
            end else
              chk($sformatf("st_rdata_hold[%0d]", k), 64'(d_rdata[k]), 64'(last_d[k]));
            sbq.delete(idx);
          end
        end
      end
    end
  end

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (busy == '0) && (sbq.size() == 0);
    end
    chk("drain", 64'(ok), 64'd1);
  endtask

  task automatic drive(bit is_d, bit we, logic [31:0] a, logic [31:0] wd);
    logic [N-1:0] g;
    if (is_d) begin
      d_we = we; d_addr = a; d_wdata = wd; d_req = '1;
    end else begin
      if_addr = a; if_req = '1;
    end
    for (int i = 0; i < 40 && (if_req | d_req) != '0; i++) begin
      @(negedge clk); g = if_gnt | d_gnt;
      @(posedge clk); #1;
      if_req &= ~g; d_req &= ~g;
    end
    chk("gnt_wait", 64'(if_req | d_req), 64'd0);
    if_req = '0; d_req = '0;
    drain();
    if (is_d && we) shadow[a] = wd;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int           t0, g0;
    int           gc [N][3];
    bit           gd [N][3];
    int           ng [N];
    int           sv [N];
    logic [N-1:0] g;
    for (int k = 0; k < N; k++) begin
      last_d[k] = '0; n_dgnt[k] = 0; n_done[k] = 0; n_men[k] = 0; ng[k] = 0;
      for (int j = 0; j < 3; j++) begin gc[k][j] = -100; gd[k][j] = 1'b1; end
    end
    // reset with both requests already high: no grant while in reset
    reset = 1'b1; if_req = '1; d_req = '1; d_we = 1'b0;
    if_addr = 32'h40; d_addr = 32'h44; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(if_gnt | d_gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_men", 64'(mem_en | mem_we), 64'd0);
    chk("rst_done", 64'(if_done | d_done), 64'd0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_maddr[%0d]", k), 64'(mem_addr[k]), 64'd0);
      chk($sformatf("rst_wdata[%0d]", k), 64'(mem_wdata[k]), 64'd0);
      chk($sformatf("rst_ifrd[%0d]", k), 64'(if_rdata[k]), 64'd0);
      chk($sformatf("rst_drd[%0d]", k), 64'(d_rdata[k]), 64'd0);
    end

    // contention straight out of reset: fetch first, then strict alternation
    @(posedge clk); #1;
    reset = 1'b0;
    t0 = cyc;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++)
        if ((if_gnt[k] || d_gnt[k]) && ng[k] < 3) begin
          gc[k][ng[k]] = cyc - t0; gd[k][ng[k]] = d_gnt[k]; ng[k]++;
        end
    end
    @(posedge clk); #1;
    if_req = '0; d_req = '0;
    drain();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rr0_cyc[%0d]", k), 64'(gc[k][0]), 64'd0);
      chk($sformatf("rr0_d[%0d]", k), 64'(gd[k][0]), 64'd0);
      chk($sformatf("rr1_cyc[%0d]", k), 64'(gc[k][1]), 64'(lat_of(k) + 3));
      chk($sformatf("rr1_d[%0d]", k), 64'(gd[k][1]), 64'd1);
      chk($sformatf("rr2_cyc[%0d]", k), 64'(gc[k][2]), 64'(2 * (lat_of(k) + 3)));
      chk($sformatf("rr2_d[%0d]", k), 64'(gd[k][2]), 64'd0);
    end

    // single fetch, store, load-back, then a short random mix
    drive(1'b0, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < N; k++)
      chk($sformatf("fetch_word[%0d]", k), 64'(if_rdata[k]), 64'hDEADBEEF);
    drive(1'b1, 1'b1, 32'h20, 32'h1234);
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < N; k++)
      chk($sformatf("ld_back[%0d]", k), 64'(d_rdata[k]), 64'h1234);
    for (int i = 0; i < 8; i++) begin
      int op = $urandom_range(0, 2);
      drive(op != 0, op == 2, 32'($urandom_range(0, 255)), $urandom);
    end

    // data request pulsed for one cycle while a fetch sits in WAIT
    if_addr = 32'h30; if_req = '1;
    @(negedge clk); g = if_gnt;
    @(posedge clk); #1;
    if_req = '0;
    chk("wd_fetch_gnt", 64'(g), 64'(3'b111));
    for (int k = 0; k < N; k++) sv[k] = n_dgnt[k] * 1000 + n_men[k];
    @(posedge clk); #1;
    d_req = '1; d_we = 1'b0; d_addr = 32'h50;
    @(posedge clk); #1;
    d_req = '0;
    drain();
    for (int k = 0; k < N; k++)
      chk($sformatf("wd_no_access[%0d]", k), 64'(n_dgnt[k] * 1000 + n_men[k]), 64'(sv[k] + 1));

    // reset while in WAIT: access abandoned, no done, then normal fetch
    if_addr = 32'h60; if_req = '1;
    @(negedge clk); g = if_gnt;
    @(posedge clk); #1;
    if_req = '0;
    chk("rm_fetch_gnt", 64'(g), 64'(3'b111));
    for (int k = 0; k < N; k++) sv[k] = n_done[k];
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rm_busy", 64'(busy), 64'd0);
    sbq.delete();
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      chk($sformatf("rm_no_done[%0d]", k), 64'(n_done[k]), 64'(sv[k]));
    g0 = cyc;
    drive(1'b0, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < N; k++)
      chk($sformatf("rm_refetch[%0d]", k), 64'(if_rdata[k]), 64'hDEADBEEF);
    chk("rm_refetch_ran", 64'(cyc > g0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
